// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (SDIV/UDIV) returning quotient, remainder and ALU flags.
// Build option: define SEQ_DIV_REMAINDER_EN to drive the sign-corrected remainder; otherwise remainder is 0.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// PREP  | absolute values, result signs, divide-by-zero short cut
// RUN   | one restoring shift/subtract step per cycle, 32 steps
// FIX   | sign correction and output register load
// DONE  | one-cycle done pulse, then back to IDLE

module seq_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic [3:0]  ALUFlags,
   output logic        div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] rem;
   logic [4:0]  count;
   logic        sgn;
   logic        q_neg;
   logic        ovf;
   logic [31:0] q_out;
   logic [3:0]  flags;
   logic        dbz;

   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic [31:0] dvd_abs;
   logic [31:0] dvs_abs;
   logic [31:0] q_fix;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_PREP;
         S_PREP: begin
            busy      = 1'b1;
            state_nxt = (dvs == 32'd0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (count == 5'd31) state_nxt = S_FIX;
         end
         S_FIX: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rem_sh  = {rem, dvd[31]};
      diff    = rem_sh - {1'b0, dvs};
      dvd_abs = (sgn && dvd[31]) ? (32'd0 - dvd) : dvd;
      dvs_abs = (sgn && dvs[31]) ? (32'd0 - dvs) : dvs;
      q_fix   = q_neg ? (32'd0 - dvd) : dvd;
   end

`ifdef SEQ_DIV_REMAINDER_EN
   logic        r_neg;
   logic [31:0] rem_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_neg   <= 1'b0;
         rem_out <= 32'd0;
      end else if (state == S_PREP) begin
         r_neg <= sgn & dvd[31];
         if (dvs == 32'd0) rem_out <= 32'd0;
      end else if (state == S_FIX) begin
         rem_out <= r_neg ? (32'd0 - rem) : rem;
      end
   end

   assign remainder = rem_out;
`else
   assign remainder = 32'd0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd   <= 32'd0;
         dvs   <= 32'd0;
         rem   <= 32'd0;
         count <= 5'd0;
         sgn   <= 1'b0;
         q_neg <= 1'b0;
         ovf   <= 1'b0;
         q_out <= 32'd0;
         flags <= 4'd0;
         dbz   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               dvd <= a;
               dvs <= b;
               sgn <= is_signed;
            end
            S_PREP: begin
               dvd   <= dvd_abs;
               dvs   <= dvs_abs;
               q_neg <= sgn & (dvd[31] ^ dvs[31]);
               ovf   <= sgn && (dvd == 32'h8000_0000) && (dvs == 32'hFFFF_FFFF);
               rem   <= 32'd0;
               count <= 5'd0;
               if (dvs == 32'd0) begin
                  q_out <= 32'd0;
                  flags <= 4'b0100;
                  dbz   <= 1'b1;
               end
            end
            S_RUN: begin
               // no borrow on the 33-bit trial subtract means the divisor fits
               rem   <= diff[32] ? rem_sh[31:0] : diff[31:0];
               dvd   <= {dvd[30:0], ~diff[32]};
               count <= count + 5'd1;
            end
            S_FIX: begin
               q_out <= q_fix;
               flags <= {q_fix[31], (q_fix == 32'd0), 1'b0, ovf};
               dbz   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign quotient    = q_out;
   assign ALUFlags    = flags;
   assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, arithmetic corner cases, ignored starts, mid-op reset.
// Remainder expectations follow SEQ_DIV_REMAINDER_EN (zero when undefined).

module tb_seq_divider;

   logic        clk;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [3:0]  ALUFlags;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .ALUFlags    (ALUFlags),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rem(input logic [31:0] r);
`ifdef SEQ_DIV_REMAINDER_EN
      return r;
`else
      return 32'd0;
`endif
   endfunction

   // drive a request for edge E0; returns just after E0 with operands scrambled
   task automatic do_start(input string tag, input logic sg, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start     = 1'b1;
      is_signed = sg;
      a         = x;
      b         = y;
      @(posedge clk);
      #1;
      start     = 1'b0;
      is_signed = ~sg;
      a         = 32'hDEAD_BEEF;
      b         = 32'd0;
      check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input string tag, output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         lat = i + 1;
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
   endtask

   task automatic run_div(input string tag, input logic sg, input logic [31:0] x, input logic [31:0] y,
                          input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                          input logic [3:0] ef, input logic edbz);
      int lat;
      do_start(tag, sg, x, y);
      wait_done(tag, lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, exp_rem(er));
      check({tag, "_flags"}, {28'd0, ALUFlags}, {28'd0, ef});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int ndone, done_edge, lat;
      logic [31:0] qseen;

      reset     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q", quotient, 32'd0);
      check("rst_r", remainder, 32'd0);
      check("rst_flags", {28'd0, ALUFlags}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_div("u100_7",   1'b0, 32'd100,        32'd7,          34, 32'd14,         32'd2,          4'b0000, 1'b0);
      run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  4'b1000, 1'b0);
      run_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  34, 32'hFFFF_FFFD,  32'd1,          4'b1000, 1'b0);
      run_div("uffff_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          34, 32'hFFFF_FFFF,  32'd0,          4'b1000, 1'b0);
      run_div("s_dbz",    1'b1, 32'd5,          32'd0,          1,  32'd0,          32'd0,          4'b0100, 1'b1);
      run_div("u_clrdbz", 1'b0, 32'd100,        32'd7,          34, 32'd14,         32'd2,          4'b0000, 1'b0);
      run_div("u_dbz",    1'b0, 32'd123,        32'd0,          1,  32'd0,          32'd0,          4'b0100, 1'b1);
      run_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  34, 32'h8000_0000,  32'd0,          4'b1001, 1'b0);
      run_div("u_big",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  34, 32'd0,          32'h8000_0000,  4'b0100, 1'b0);

      // starts at E5 and E34 during a busy 100/7 are ignored; E36 is accepted
      do_start("ign", 1'b0, 32'd100, 32'd7);
      ndone     = 0;
      done_edge = -1;
      qseen     = 32'd0;
      for (int e = 1; e <= 37; e++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            done_edge = e - 1;
            qseen     = quotient;
         end
         if (e == 37) check("ign_accept_e36", {31'd0, busy}, 32'd1);
         start     = (e == 5 || e == 34 || e == 36);
         is_signed = 1'b0;
         a         = 32'd9;
         b         = 32'd3;
      end
      start = 1'b0;
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_done_edge", 32'(done_edge), 32'd34);
      check("ign_q", qseen, 32'd14);
      wait_done("acc", lat);
      check("acc_lat", 32'(lat), 32'd34);
      check("acc_q", quotient, 32'd3);
      check("acc_r", remainder, 32'd0);

      // reset asserted right after E10 aborts the operation
      do_start("rstmid", 1'b0, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_done", {31'd0, done}, 32'd0);
      check("rstmid_q", quotient, 32'd0);
      check("rstmid_flags", {28'd0, ALUFlags}, 32'd0);
      check("rstmid_r", remainder, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("rstmid_nodone", 32'(ndone), 32'd0);
      run_div("post_rst", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 4'b0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 divider that serves integer divide requests (SDIV/UDIV) for the execute stage, replacing single-cycle combinational division. It accepts one operand pair per request and returns the quotient, the remainder and the ALU flag nibble after a fixed latency. It signals completion with a one-cycle `done` pulse. The pipeline holds the issuing instruction in execute while `busy` is high.

## Interface
- No parameters; operand width fixed at 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous and active-low.
- `start` input 1: request strobe, accepted only in IDLE.
- `is_signed` input 1: 1 = signed (SDIV), 0 = unsigned (UDIV); sampled with `start`.
- `a` input 32: dividend, sampled with `start`.
- `b` input 32: divisor, sampled with `start`.
- `busy` output 1: high in PREP, RUN and FIX.
- `done` output 1: one-cycle pulse; results are valid in that cycle.
- `quotient` output 32: registered quotient.
- `remainder` output 32: registered remainder (see Configuration).
- `ALUFlags` output 4: {Negative, Zero, Carry, Overflow} for `quotient`.
- `div_by_zero` output 1: registered, set with `done` when `b` was 0.

## Operation
- States:
  - IDLE: if `start`, latch operands and `is_signed`, then go to PREP.
  - PREP: take absolute values when signed, record the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
    - If `b`==0, load results and go to DONE.
    - Otherwise clear the partial remainder, set count=0 and go to RUN.
  - RUN: one restoring step per cycle.
    - Shift {rem,dvd} left by 1.
    - Trial-subtract the divisor on 33 bits; if there is no borrow, keep the difference and set the quotient LSB.
    - After 32 steps (count 31), go to FIX.
  - FIX: negate the quotient and/or remainder per the recorded signs, load the output registers, then go to DONE.
  - DONE: `done`=1, then go to IDLE unconditionally.
- Arithmetic:
  - Truncating division: quotient rounds toward zero, and the remainder takes the sign of the dividend.
  - Divide by zero: `quotient`=0, `remainder`=0, `div_by_zero`=1.
  - Signed 0x80000000 / 0xFFFFFFFF: `quotient`=0x80000000, `remainder`=0, Overflow flag=1.
- Flags:
  - N = quotient[31].
  - Z = (quotient==0).
  - C = 0 always.
  - V = 1 only in the signed overflow case above.
- `start` is ignored outside IDLE, including in DONE; no queuing.
- Operand changes after acceptance have no effect.
- Outputs hold their last values until the next FIX or divide-by-zero PREP load.
- `div_by_zero` and V are cleared on every result load.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `ALUFlags`=0, `div_by_zero`=0; counters cleared.
- Reset asserted mid-operation aborts immediately and no `done` is produced.
- Normal request, with `start` sampled at edge E0:
  - E1 enters RUN.
  - E2..E33 perform the 32 iterations.
  - E34 enters DONE with results loaded.
  - `done` is high for the cycle between E34 and E35.
  - `busy` is high from E0 to E34.
- Divide by zero: PREP goes to DONE at E1, and `done` is high between E1 and E2.
- Back-to-back: the earliest next acceptance is E36, because E35 returns the block to IDLE.

## Configuration
- `SEQ_DIV_REMAINDER_EN`:
  - Defined: `remainder` carries the sign-corrected remainder as specified.
  - Undefined: `remainder` is constant 0, remainder sign correction is omitted, and quotient, flags and timing are unchanged.

## Test plan
- Unsigned 100/7:
  - `start` at E0 -> `done` between E34 and E35.
  - `quotient`=14, `remainder`=2, `ALUFlags`=4'b0000.
- Signed -7/2:
  - `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF, N=1.
  - Unsigned 0xFFFFFFFF/1 -> `quotient`=0xFFFFFFFF, `remainder`=0, N=1.
- `b`=0, signed and unsigned:
  - `done` at E1–E2.
  - `quotient`=0, `remainder`=0, `div_by_zero`=1, Z=1.
  - The next valid divide clears `div_by_zero`.
- Signed 0x80000000 / 0xFFFFFFFF:
  - `quotient`=0x80000000, `remainder`=0, `ALUFlags`=4'b1001.
- `start` pulsed with new operands at E5 and E34 during a busy 100/7:
  - Both are ignored; only one `done` occurs, with `quotient`=14.
  - `start` at E36 is accepted.
- Reset low at E10 of an operation:
  - All outputs reset immediately and no `done` follows.
  - After release, 9/3 -> `quotient`=3, `remainder`=0.
  - With `SEQ_DIV_REMAINDER_EN` undefined, `remainder` stays 0.
